// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V load/store size codes, LSU state type and access helpers
// Contents:
//   LDST_*            load/store size codes (RV32 funct3 encoding)
//   lsu_state_t       LSU FSM states
//   ldst_legal        size code is one of B/H/W/BU/HU
//   ldst_misaligned   legal size whose address is not naturally aligned
//   ldst_be           byte-enable mask for a size and address low bits
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RESP} lsu_state_t;

    function automatic logic ldst_legal(input logic [2:0] size);
        return (size == LDST_B)  || (size == LDST_H)  || (size == LDST_W) ||
               (size == LDST_BU) || (size == LDST_HU);
    endfunction

    // Only meaningful for legal sizes; illegal codes report aligned so they
    // surface as a size fault rather than a misalignment.
    function automatic logic ldst_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LDST_H, LDST_HU: mis = addr_lo[0];
            LDST_W:          mis = (addr_lo != 2'b00);
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] ldst_be(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << addr_lo;
            LDST_H, LDST_HU: be = 4'b0011 << {addr_lo[1], 1'b0};
            LDST_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - data-memory bus between the LSU (master) and memory (slave)
// Signals:
//   req    bus request, held for the whole transaction
//   we     1=write, 0=read
//   be     byte enables
//   addr   full byte address
//   wd     write data (lane-replicated)
//   rd     read data, valid with ready
//   ready  transaction completes this cycle
interface riscv_lsu_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;

    modport master (output req, we, be, addr, wd, input rd, ready);
    modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_lsu_load_align.sv
// rtl/riscv_lsu_load_align.sv - combinational load-data lane select and sign/zero extension
// Ports:
//   i_size  LDST_* size code of the load
//   i_addr  address bits [1:0]
//   i_word  raw 32-bit word from the bus
//   o_data  extended load result
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

        case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_data = {24'h000000, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_data = {16'h0000, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load-store unit: one bus transaction per core request, stall until response
// Parameters:
//   TIMEOUT_CYCLES   REQ cycles without ready before the access is faulted
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   core_req_i            access requested (held while core_stall_o=1)
//   core_we_i             1=store, 0=load
//   core_size_i           LDST_* size code
//   core_addr_i           byte address
//   core_wd_i             store data (rs2)
//   core_rd_o             extended load data, valid in RESP
//   core_stall_o          freeze pipeline
//   core_misalign_o       misaligned access, 1-cycle pulse
//   core_fault_o          illegal size or bus timeout, 1-cycle pulse
//   mem                   data-memory bus (master side)
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        core_fault_o,
    riscv_lsu_if.master mem
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [CW-1:0] r_cnt;

    logic        w_legal;
    logic        w_mis;
    logic        w_accept;
    logic        w_cnt_last;
    logic [31:0] w_ext;
    logic [31:0] w_wd_rep;

    assign w_legal    = ldst_legal(core_size_i);
    assign w_mis      = ldst_misaligned(core_size_i, core_addr_i[1:0]);
    assign w_cnt_last = (r_cnt == C_LAST);

    lsu_load_align u_align (
        .i_size (r_size),
        .i_addr (r_addr[1:0]),
        .i_word (r_rdata),
        .o_data (w_ext)
    );

    // Narrow stores are replicated across all lanes so the memory can take
    // whichever lane the byte enables select.
    always_comb begin
        case (r_size)
            LDST_B, LDST_BU: w_wd_rep = {4{r_wd[7:0]}};
            LDST_H, LDST_HU: w_wd_rep = {2{r_wd[15:0]}};
            default:         w_wd_rep = r_wd;
        endcase
    end

    always_comb begin
        w_next          = r_state;
        w_accept        = 1'b0;
        core_rd_o       = 32'h0;
        core_stall_o    = 1'b0;
        core_misalign_o = 1'b0;
        core_fault_o    = 1'b0;
        mem.req         = 1'b0;
        mem.we          = 1'b0;
        mem.be          = 4'h0;
        mem.addr        = 32'h0;
        mem.wd          = 32'h0;

        case (r_state)
            LSU_IDLE: begin
                // Rejections are answered in the same cycle without touching the bus.
                if (core_req_i && !rst_i) begin
                    if (!w_legal) begin
                        core_fault_o = 1'b1;
                    end else if (w_mis) begin
                        core_misalign_o = 1'b1;
                    end else begin
                        core_stall_o = 1'b1;
                        w_accept     = 1'b1;
                        w_next       = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                core_stall_o = 1'b1;
                mem.req      = 1'b1;
                mem.we       = r_we;
                mem.be       = ldst_be(r_size, r_addr[1:0]);
                mem.addr     = r_addr;
                mem.wd       = w_wd_rep;
                if (mem.ready || w_cnt_last) begin
                    w_next = LSU_RESP;
                end
            end
            LSU_RESP: begin
                core_rd_o    = (r_we || r_fault) ? 32'h0 : w_ext;
                core_fault_o = r_fault && !rst_i;
                w_next       = LSU_IDLE;
            end
            default: w_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LSU_IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= 32'h0;
            r_wd    <= 32'h0;
            r_rdata <= 32'h0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_we    <= core_we_i;
                        r_size  <= core_size_i;
                        r_addr  <= core_addr_i;
                        r_wd    <= core_wd_i;
                        r_rdata <= 32'h0;
                        r_fault <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                LSU_REQ: begin
                    if (mem.ready) begin
                        r_rdata <= mem.rd;
                    end else if (w_cnt_last) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu: vector table, reset sequence, random accesses
module tb_riscv_lsu;
    import riscv_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_mis;
    logic        core_flt;

    riscv_lsu_if mem_bus ();

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .core_req_i      (core_req),
        .core_we_i       (core_we),
        .core_size_i     (core_size),
        .core_addr_i     (core_addr),
        .core_wd_i       (core_wd),
        .core_rd_o       (core_rd),
        .core_stall_o    (core_stall),
        .core_misalign_o (core_mis),
        .core_fault_o    (core_flt),
        .mem             (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis_now;
        logic        flt_now;
        logic        stall_now;
        int          req_cyc;
        int          stall_cyc;
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        flt_resp;
        logic        stall_resp;
    } obs_t;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          delay;
        logic        mis;
        logic        flt;
        int          reqc;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] crd;
        logic        flt_resp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_obs(input string tag, input obs_t a, input obs_t e, input logic chk_wd);
        check({tag, " misalign"}, 32'(a.mis_now), 32'(e.mis_now));
        check({tag, " fault_now"}, 32'(a.flt_now), 32'(e.flt_now));
        check({tag, " stall_now"}, 32'(a.stall_now), 32'(e.stall_now));
        check({tag, " req_cycles"}, a.req_cyc, e.req_cyc);
        check({tag, " stall_cycles"}, a.stall_cyc, e.stall_cyc);
        check({tag, " be"}, 32'(a.be), 32'(e.be));
        check({tag, " we"}, 32'(a.we), 32'(e.we));
        check({tag, " addr"}, a.addr, e.addr);
        if (chk_wd) check({tag, " wd"}, a.wd, e.wd);
        check({tag, " core_rd"}, a.rd, e.rd);
        check({tag, " fault_resp"}, 32'(a.flt_resp), 32'(e.flt_resp));
        check({tag, " stall_resp"}, 32'(a.stall_resp), 32'(e.stall_resp));
    endtask

    // Reference: access outcome from size/alignment rules with plain arithmetic.
    function automatic obs_t model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd, input int delay);
        obs_t e;
        int n;
        bit legal, tmo;
        logic [31:0] mask, v;
        e = '{default: 0};
        legal = (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = (size == 3'd2) ? 4 : ((size == 3'd1 || size == 3'd5) ? 2 : 1);
        if (!legal) begin
            e.flt_now = 1'b1;
        end else if (addr % n != 0) begin
            e.mis_now = 1'b1;
        end else begin
            tmo = (delay < 0) || (delay >= TO);
            e.stall_now = 1'b1;
            e.req_cyc   = tmo ? TO : delay + 1;
            e.stall_cyc = e.req_cyc + 1;
            e.be   = 4'(((1 << n) - 1) << (addr % 4));
            e.we   = we;
            e.addr = addr;
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            e.wd = (wd & mask) * ((n == 1) ? 32'h0101_0101 : ((n == 2) ? 32'h0001_0001 : 32'd1));
            if (!we && !tmo) begin
                v = (rd >> (8 * (addr % 4))) & mask;
                if ((size == 3'd0 || size == 3'd1) && v[8 * n - 1]) v = v | ~mask;
                e.rd = v;
            end
            e.flt_resp = tmo;
        end
        return e;
    endfunction

    // Drives one core access and plays the memory: ready after `delay` REQ cycles (never if <0).
    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int delay,
                             output obs_t o);
        int k;
        bit done;
        o = '{default: 0};
        @(posedge clk); #1;
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        mem_bus.ready = 1'b0;
        mem_bus.rd    = $urandom;
        #2;
        o.mis_now   = core_mis;
        o.flt_now   = core_flt;
        o.stall_now = core_stall;
        if (!core_stall) begin
            @(posedge clk); #1;
            core_req = 1'b0;
            if (mem_bus.req) o.req_cyc++;
        end else begin
            o.stall_cyc = 1;
            k = 0;
            done = 0;
            while (!done) begin
                @(posedge clk); #1;
                if (mem_bus.req) begin
                    if (k == 0) begin
                        o.be   = mem_bus.be;
                        o.we   = mem_bus.we;
                        o.addr = mem_bus.addr;
                        o.wd   = mem_bus.wd;
                    end
                    o.req_cyc++;
                    if (core_stall) o.stall_cyc++;
                    mem_bus.ready = (k == delay);
                    mem_bus.rd    = (k == delay) ? rd : $urandom;
                    k++;
                    if (k > 20) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL bus_bound: request still open after %0d cycles, required at most %0d", k, TO);
                        done = 1;
                    end
                end else begin
                    mem_bus.ready = 1'($urandom_range(0, 1));
                    mem_bus.rd    = $urandom;
                    #2;
                    o.rd         = core_rd;
                    o.flt_resp   = core_flt;
                    o.stall_resp = core_stall;
                    done = 1;
                end
            end
            @(posedge clk); #1;
            core_req = 1'b0;
            mem_bus.ready = 1'b0;
        end
    endtask

    vec_t vt [14];

    initial begin
        obs_t o, e;
        rst       = 1'b1;
        core_req  = 1'b0;
        core_we   = 1'b0;
        core_size = 3'b000;
        core_addr = 32'h0;
        core_wd   = 32'h0;
        mem_bus.ready = 1'b0;
        mem_bus.rd    = 32'h0;

        vt[0]  = '{1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        0, 1'b0, 1'b0, 1, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 3'd0, 32'h203, 32'h0,        32'h80FFFF7F, 0, 1'b0, 1'b0, 1, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0};
        vt[2]  = '{1'b0, 3'd4, 32'h203, 32'h0,        32'h80FFFF7F, 0, 1'b0, 1'b0, 1, 4'h8, 32'h0,        32'h00000080, 1'b0};
        vt[3]  = '{1'b1, 3'd1, 32'h12,  32'h0000A55A, 32'h0,        1, 1'b0, 1'b0, 2, 4'hC, 32'hA55AA55A, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 3'd5, 32'h12,  32'h0,        32'hA55A0000, 0, 1'b0, 1'b0, 1, 4'hC, 32'h0,        32'h0000A55A, 1'b0};
        vt[5]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h0,        0, 1'b1, 1'b0, 0, 4'h0, 32'h0,        32'h0,        1'b0};
        vt[6]  = '{1'b0, 3'd7, 32'h100, 32'h0,        32'h0,        0, 1'b0, 1'b1, 0, 4'h0, 32'h0,        32'h0,        1'b0};
        vt[7]  = '{1'b1, 3'd2, 32'h200, 32'h12345678, 32'h0,       -1, 1'b0, 1'b0, 4, 4'hF, 32'h12345678, 32'h0,        1'b1};
        vt[8]  = '{1'b0, 3'd1, 32'h2,   32'h0,        32'h80010000, 2, 1'b0, 1'b0, 3, 4'hC, 32'h0,        32'hFFFF8001, 1'b0};
        vt[9]  = '{1'b1, 3'd0, 32'h1,   32'h000000AB, 32'h0,        0, 1'b0, 1'b0, 1, 4'h2, 32'hABABABAB, 32'h0,        1'b0};
        vt[10] = '{1'b0, 3'd2, 32'h8,   32'h0,        32'hCAFEF00D,-1, 1'b0, 1'b0, 4, 4'hF, 32'h0,        32'h0,        1'b1};
        vt[11] = '{1'b0, 3'd3, 32'h1,   32'h0,        32'h0,        0, 1'b0, 1'b1, 0, 4'h0, 32'h0,        32'h0,        1'b0};
        vt[12] = '{1'b0, 3'd1, 32'h3,   32'h0,        32'h0,        0, 1'b1, 1'b0, 0, 4'h0, 32'h0,        32'h0,        1'b0};
        vt[13] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h13572468, 3, 1'b0, 1'b0, 4, 4'hF, 32'h0,        32'h13572468, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst mem_req", 32'(mem_bus.req), 32'h0);
        check("rst mem_be", 32'(mem_bus.be), 32'h0);
        check("rst mem_addr", mem_bus.addr, 32'h0);
        check("rst mem_wd", mem_bus.wd, 32'h0);
        check("rst core_rd", core_rd, 32'h0);
        check("rst stall", 32'(core_stall), 32'h0);
        check("rst misalign", 32'(core_mis), 32'h0);
        check("rst fault", 32'(core_flt), 32'h0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 14; i++) begin
            e = '{default: 0};
            e.mis_now   = vt[i].mis;
            e.flt_now   = vt[i].flt;
            e.stall_now = !(vt[i].mis || vt[i].flt);
            e.req_cyc   = vt[i].reqc;
            e.stall_cyc = e.stall_now ? vt[i].reqc + 1 : 0;
            e.be        = vt[i].be;
            e.we        = e.stall_now ? vt[i].we : 1'b0;
            e.addr      = e.stall_now ? vt[i].addr : 32'h0;
            e.wd        = vt[i].mwd;
            e.rd        = vt[i].crd;
            e.flt_resp  = vt[i].flt_resp;
            do_access(vt[i].we, vt[i].size, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].delay, o);
            compare_obs($sformatf("vec%0d", i), o, e, e.stall_now && vt[i].we);
        end

        // Reset during the second REQ cycle, then a normal load
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h40;
        mem_bus.ready = 1'b0;
        #2;
        check("rstseq accept stall", 32'(core_stall), 32'h1);
        @(posedge clk); #1;
        check("rstseq req1", 32'(mem_bus.req), 32'h1);
        @(posedge clk); #1;
        check("rstseq req2", 32'(mem_bus.req), 32'h1);
        rst = 1'b1;
        core_req = 1'b0;
        #2;
        check("rstseq fault in rst", 32'(core_flt), 32'h0);
        check("rstseq misalign in rst", 32'(core_mis), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstseq req dropped", 32'(mem_bus.req), 32'h0);
        check("rstseq stall dropped", 32'(core_stall), 32'h0);
        check("rstseq no fault", 32'(core_flt), 32'h0);
        @(posedge clk); #1;
        check("rstseq idle req", 32'(mem_bus.req), 32'h0);
        check("rstseq idle fault", 32'(core_flt), 32'h0);
        do_access(1'b0, 3'd2, 32'h40, 32'h0, 32'h0BADF00D, 0, o);
        e = model(1'b0, 3'd2, 32'h40, 32'h0, 32'h0BADF00D, 0);
        compare_obs("post_rst_lw", o, e, 1'b0);

        // Random accesses against the reference model
        for (int i = 0; i < 60; i++) begin
            logic        r_we;
            logic [2:0]  r_size;
            logic [31:0] r_addr, r_wd, r_rd;
            int          r_delay;
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 3'($urandom_range(0, 7));
            r_addr  = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr[1:0] = 2'b00;
            else if ($urandom_range(0, 1) != 0) r_addr[0] = 1'b0;
            r_wd    = $urandom;
            r_rd    = $urandom;
            r_delay = $urandom_range(0, 5);
            if (r_delay == 5) r_delay = -1;
            e = model(r_we, r_size, r_addr, r_wd, r_rd, r_delay);
            do_access(r_we, r_size, r_addr, r_wd, r_rd, r_delay, o);
            compare_obs($sformatf("rnd%0d", i), o, e, e.stall_now && r_we);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
